fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
// Single-port owner of the 512x512x1 SPRAM framebuffer. Sits between the dither stage's
// 16-pixel mono words (writer) and the CRT scan-out fetch (reader).
// Reads have hard real-time priority. Writes that collide with a read are queued in a
// small FIFO and retired in free slots instead of being dropped.
// Also runs a background clear-screen sweep.
// PARAMETERS
// FIFO_DEPTH  4    write-queue entries (power of 2, >=2)
// FB_WIDTH    512  pixels per line; words with xaddr >= FB_WIDTH are discarded
// FB_HEIGHT   512  lines; words with yaddr >= FB_HEIGHT are discarded
// ADDR_BITS   14   SPRAM word address width = log2(FB_HEIGHT) + log2(FB_WIDTH/16)
// DROP_BITS   8    width of the saturating drop counter
// PORTS
// clk_16mhz      in   1          pixel clock; the only clock
// reset_n        in   1          synchronous, active-low reset
// in_valid       in   1          one-cycle strobe: in_bits/in_xaddr/in_yaddr valid
// in_bits        in   16         mono pixels, bit 15 = leftmost
// in_xaddr       in   12         x of the leftmost pixel; bits [3:0] ignored
// in_yaddr       in   12         line number
// rd_req         in   1          scan-out fetch request (highest priority, never stalled)
// rd_addr        in   ADDR_BITS  fetch word address
// rd_data        out  16         fetched word
// rd_valid       out  1          rd_data valid, exactly 1 cycle after rd_req
// clear_req      in   1          strobe: start a clear sweep
// clear_pattern  in   16         word written to every address; sampled at clear start
// clear_busy     out  1          sweep in progress
// sp_addr        out  ADDR_BITS  SPRAM address
// sp_wen         out  1          SPRAM write enable
// sp_wdata       out  16         SPRAM write data
// sp_rdata       in   16         SPRAM read data, valid the cycle after the read address
// fifo_level     out  log2(D)+1  current queue occupancy
// drop_count     out  DROP_BITS  words lost to a full queue; saturates at all-ones
// BEHAVIOUR
// - Reset (reset_n=0 at a clk edge): FIFO empty; state IDLE.
//   All of these are 0: sp_wen, rd_valid, clear_busy, drop_count, fifo_level, sp_addr.
//   Reset mid-sweep aborts the sweep; no resume.
// - Address map: wr_addr = {in_yaddr[8:0], in_xaddr[8:4]}.
//   The window check on full 12-bit x/y comes before the push. Out-of-window words are
//   discarded and are not counted.
// - Per-cycle SPRAM slot priority:
//   1. rd_req: sp_addr = rd_addr, sp_wen = 0.
//   2. Else in IDLE with FIFO non-empty: pop the head; sp_wen = 1 with its addr/data.
//   3. Else in CLEAR: write clear_pattern at clr_ptr; clr_ptr += 1.
//   4. Else: sp_wen = 0 and sp_addr holds its value.
// - Output timing:
//   - sp_* are combinational from the slot decision; no extra register.
//   - rd_valid is registered rd_req.
//   - rd_data = sp_rdata, passed through.
// - Push rules:
//   - An in-window in_valid pushes at that edge; the earliest write is 1 cycle later.
//   - When full, the push succeeds only if a pop occurs in the same cycle.
//   - Otherwise the word is dropped and drop_count += 1 (saturating).
//   - A push and a pop on an empty FIFO are not bypassed; the pop comes the next cycle.
// - FSM IDLE -> CLEAR:
//   - Taken on clear_req in IDLE.
//   - Flush the FIFO (fifo_level -> 0 next cycle).
//   - clr_ptr = 0; latch clear_pattern; clear_busy = 1 from the next cycle.
// - In CLEAR:
//   - in_valid words are discarded (not counted).
//   - clear_req is ignored.
//   - rd_req still wins every slot it asks for.
// - CLEAR -> IDLE after the write at clr_ptr = 2^ADDR_BITS-1.
//   clear_busy falls the cycle after that write.
// - Nothing is allowed to reach the same address through two paths in one cycle.
//   The FIFO preserves order, so a later word to the same address always lands last.
// STRUCTURE
// - Shared package fb_pkg: FB_WIDTH, FB_HEIGHT, ADDR_BITS, the fb_word_addr(x,y) function,
//   and the state encoding {ST_IDLE, ST_CLEAR}.
// - One sub-module, fb_wr_fifo (sync FIFO, ADDR_BITS+16 wide):
//   - push/pop/flush inputs; full/empty/level outputs.
//   - Pop-when-full frees space for a same-cycle push.
// - Arbitration, FSM, window check and counters live in the top level.
// TESTING
// 1. Single write, no reads: in_valid, x=32, y=3, bits=16'hA5A5.
//    -> next cycle sp_wen=1, sp_addr=14'h0062, sp_wdata=16'hA5A5.
// 2. Collision: rd_req held for 3 cycles while pushing words at y=0, x=0/16/32.
//    -> no sp_wen during rd_req; addresses 0,1,2 are written in order on the 3 following cycles.
//    -> rd_valid tracks rd_req delayed by 1.
// 3. Overflow: rd_req held 10 cycles, 6 pushes.
//    -> fifo_level=4, drop_count=2, only the first 4 words are written afterwards.
//    -> then 300 further drops -> drop_count=255.
// 4. Window: push x=512, y=0 and x=0, y=600.
//    -> no sp_wen, drop_count unchanged, fifo_level=0.
// 5. Clear: clear_req with pattern 16'hFFFF, rd_req every 16th cycle.
//    -> 16384 writes of FFFF, none overlapping a read.
//    -> clear_busy deasserts after address 16383; in_valid during the sweep has no effect.
// 6. Reset mid-sweep at clr_ptr=100 with 2 words queued.
//    -> every output listed under Reset is at its value the next cycle.
//    -> a fresh push is then written normally.

Source files
------------

// File: rtl/fb_write_arbiter_pkg.sv
// Shared framebuffer geometry, word-address mapping and arbiter state encoding.
package fb_pkg;

  localparam int FB_WIDTH  = 512;
  localparam int FB_HEIGHT = 512;
  localparam int X_BITS    = $clog2(FB_WIDTH / 16);
  localparam int Y_BITS    = $clog2(FB_HEIGHT);
  localparam int ADDR_BITS = X_BITS + Y_BITS;

  typedef enum logic {ST_IDLE, ST_CLEAR} fb_state_t;

  // One SPRAM word holds 16 horizontally adjacent pixels of a single line.
  function automatic logic [ADDR_BITS-1:0] fb_word_addr(input logic [11:0] x, input logic [11:0] y);
    return {y[Y_BITS-1:0], x[X_BITS+3:4]};
  endfunction

  function automatic logic fb_in_window(input logic [11:0] x, input logic [11:0] y);
    return (x < 12'(FB_WIDTH)) && (y < 12'(FB_HEIGHT));
  endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Writer, scan-out, clear-control and SPRAM signals of the framebuffer arbiter.
interface fb_write_arbiter_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_BITS  = 8
);
  import fb_pkg::*;

  localparam int LEVEL_BITS = $clog2(FIFO_DEPTH) + 1;

  logic                  in_valid;
  logic [15:0]           in_bits;
  logic [11:0]           in_xaddr;
  logic [11:0]           in_yaddr;
  logic                  rd_req;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic [15:0]           rd_data;
  logic                  rd_valid;
  logic                  clear_req;
  logic [15:0]           clear_pattern;
  logic                  clear_busy;
  logic [ADDR_BITS-1:0]  sp_addr;
  logic                  sp_wen;
  logic [15:0]           sp_wdata;
  logic [15:0]           sp_rdata;
  logic [LEVEL_BITS-1:0] fifo_level;
  logic [DROP_BITS-1:0]  drop_count;

  modport master (
    output in_valid, in_bits, in_xaddr, in_yaddr, rd_req, rd_addr,
           clear_req, clear_pattern, sp_rdata,
    input  rd_data, rd_valid, clear_busy, sp_addr, sp_wen, sp_wdata,
           fifo_level, drop_count
  );

  modport slave (
    input  in_valid, in_bits, in_xaddr, in_yaddr, rd_req, rd_addr,
           clear_req, clear_pattern, sp_rdata,
    output rd_data, rd_valid, clear_busy, sp_addr, sp_wen, sp_wdata,
           fifo_level, drop_count
  );

endinterface

// File: rtl/fb_write_arbiter_wr_fifo.sv
// Synchronous write queue; a pop on a full queue makes room for a same-cycle push.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 30
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_BITS = $clog2(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count;
  logic                do_push;
  logic                do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_BITS + 1)'(DEPTH));
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Single-port SPRAM owner: scan-out reads first, queued pixel writes next, clear sweep last.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_BITS  = 8
) (
  input  logic               clk_16mhz,
  input  logic               reset_n,
  fb_write_arbiter_if.slave  bus
);
  localparam int LEVEL_BITS = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_BITS = ADDR_BITS + 16;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  fb_state_t             state;
  logic [ADDR_BITS-1:0]  clr_ptr;
  logic [ADDR_BITS-1:0]  sp_addr_hold;
  logic [15:0]           clr_pattern;
  logic                  clear_busy_q;
  logic                  rd_valid_q;
  logic [DROP_BITS-1:0]  drop_count_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_flush;
  logic [ENTRY_BITS-1:0] fifo_head;
  logic [LEVEL_BITS-1:0] fifo_level;
  logic                  push_req;
  logic                  clr_write;
  logic                  drop;

  // Words arriving while a clear is starting or running are discarded, not counted.
  assign push_req   = bus.in_valid && (state == ST_IDLE) && !bus.clear_req
                      && fb_in_window(bus.in_xaddr, bus.in_yaddr);
  assign fifo_pop   = !bus.rd_req && (state == ST_IDLE) && !fifo_empty;
  assign clr_write  = !bus.rd_req && (state == ST_CLEAR);
  assign fifo_push  = push_req && (!fifo_full || fifo_pop);
  assign drop       = push_req && fifo_full && !fifo_pop;
  assign fifo_flush = (state == ST_IDLE) && bus.clear_req;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_BITS)
  ) u_fifo (
    .clk     (clk_16mhz),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .wdata   ({fb_word_addr(bus.in_xaddr, bus.in_yaddr), bus.in_bits}),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    bus.sp_wen   = 1'b0;
    bus.sp_addr  = sp_addr_hold;
    bus.sp_wdata = '0;
    if (bus.rd_req) begin
      bus.sp_addr = bus.rd_addr;
    end else if (fifo_pop) begin
      bus.sp_wen   = 1'b1;
      bus.sp_addr  = fifo_head[ENTRY_BITS-1:16];
      bus.sp_wdata = fifo_head[15:0];
    end else if (clr_write) begin
      bus.sp_wen   = 1'b1;
      bus.sp_addr  = clr_ptr;
      bus.sp_wdata = clr_pattern;
    end
  end

  always_ff @(posedge clk_16mhz) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      clr_ptr      <= '0;
      clr_pattern  <= '0;
      clear_busy_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.clear_req) begin
            state        <= ST_CLEAR;
            clr_ptr      <= '0;
            clr_pattern  <= bus.clear_pattern;
            clear_busy_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_write) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == LAST_ADDR) begin
              state        <= ST_IDLE;
              clear_busy_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_16mhz) begin
    if (!reset_n) begin
      rd_valid_q   <= 1'b0;
      sp_addr_hold <= '0;
      drop_count_q <= '0;
    end else begin
      rd_valid_q   <= bus.rd_req;
      sp_addr_hold <= bus.sp_addr;
      if (drop && (drop_count_q != '1)) drop_count_q <= drop_count_q + 1'b1;
    end
  end

  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = bus.sp_rdata;
  assign bus.clear_busy = clear_busy_q;
  assign bus.fifo_level = fifo_level;
  assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: vector table, write scoreboard and clear/reset sequences.
module tb_fb_write_arbiter;
  import fb_pkg::*;

  typedef struct {
    logic [13:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [15:0] bits;
    logic        expect_write;
    logic [13:0] exp_addr;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  fb_write_arbiter_if #(.FIFO_DEPTH(4), .DROP_BITS(8)) bus ();

  fb_write_arbiter #(.FIFO_DEPTH(4), .DROP_BITS(8)) dut (
    .clk_16mhz (clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  // Behavioural SPRAM: write on the edge, registered read of the presented address.
  logic [15:0] spram [16384];
  always @(posedge clk) begin
    if (bus.sp_wen) spram[bus.sp_addr] <= bus.sp_wdata;
    bus.sp_rdata <= spram[bus.sp_addr];
  end

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  bit          clr_mode = 1'b0;
  int          clr_writes = 0;
  int          clr_bad = 0;
  logic [13:0] clr_expect = '0;
  logic [15:0] clr_pat_exp = '0;
  int          unexp_writes = 0;
  int          overlap_errs = 0;
  int          rdv_errs = 0;
  logic        prev_rd_req = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [13:0] tb_addr(input int x, input int y);
    return 14'(y * 32 + x / 16);
  endfunction

  task automatic expectWrite(input logic [13:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic applyStimulus(input logic v, input logic [11:0] x, input logic [11:0] y,
                               input logic [15:0] b, input logic rd, input logic [13:0] ra);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_xaddr = x;
    bus.in_yaddr = y;
    bus.in_bits  = b;
    bus.rd_req   = rd;
    bus.rd_addr  = ra;
  endtask

  task automatic startClear(input logic [15:0] pat);
    @(posedge clk);
    #1;
    bus.in_valid      = 1'b0;
    bus.rd_req        = 1'b0;
    bus.clear_req     = 1'b1;
    bus.clear_pattern = pat;
    @(posedge clk);
    #1;
    bus.clear_req     = 1'b0;
    bus.clear_pattern = 16'h0;
  endtask

  // Scoreboard and per-cycle protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.sp_wen && bus.rd_req) overlap_errs++;
      if (bus.rd_valid !== prev_rd_req) rdv_errs++;
      prev_rd_req = bus.rd_req;
      if (bus.sp_wen) begin
        if (clr_mode) begin
          clr_writes++;
          if (bus.sp_addr !== clr_expect || bus.sp_wdata !== clr_pat_exp) clr_bad++;
          clr_expect = clr_expect + 14'd1;
        end else if (exp_q.size() == 0) begin
          unexp_writes++;
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("wr_addr", 32'(bus.sp_addr), 32'(mon_e.addr));
          checkOutput("wr_data", 32'(bus.sp_wdata), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    vec_t vecs[8];
    bit   done;

    vecs[0] = '{12'd32,   12'd3,    16'hA5A5, 1'b1, 14'h0062};
    vecs[1] = '{12'd0,    12'd0,    16'h1234, 1'b1, 14'h0000};
    vecs[2] = '{12'd511,  12'd511,  16'h5A5A, 1'b1, 14'h3FFF};
    vecs[3] = '{12'd496,  12'd0,    16'h0F0F, 1'b1, 14'h001F};
    vecs[4] = '{12'd31,   12'd1,    16'hC3C3, 1'b1, 14'h0021};
    vecs[5] = '{12'd512,  12'd0,    16'hDEAD, 1'b0, 14'h0000};
    vecs[6] = '{12'd0,    12'd600,  16'hBEEF, 1'b0, 14'h0000};
    vecs[7] = '{12'd4095, 12'd4095, 16'hFFFF, 1'b0, 14'h0000};

    reset_n           = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_xaddr      = '0;
    bus.in_yaddr      = '0;
    bus.in_bits       = '0;
    bus.rd_req        = 1'b0;
    bus.rd_addr       = '0;
    bus.clear_req     = 1'b0;
    bus.clear_pattern = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_sp_wen",     32'(bus.sp_wen),     0);
    checkOutput("rst_rd_valid",   32'(bus.rd_valid),   0);
    checkOutput("rst_clear_busy", 32'(bus.clear_busy), 0);
    checkOutput("rst_drop_count", 32'(bus.drop_count), 0);
    checkOutput("rst_fifo_level", 32'(bus.fifo_level), 0);
    checkOutput("rst_sp_addr",    32'(bus.sp_addr),    0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    $display("[TB] single writes and window checks");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].x, vecs[i].y, vecs[i].bits, 1'b0, 14'h0);
      if (vecs[i].expect_write) expectWrite(vecs[i].exp_addr, vecs[i].bits);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_no_bypass", i), 32'(bus.sp_wen), 0);
      applyStimulus(1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 14'h0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_wen", i), 32'(bus.sp_wen), 32'(vecs[i].expect_write));
    end
    repeat (2) applyStimulus(1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 14'h0);
    @(negedge clk);
    checkOutput("win_drop_count", 32'(bus.drop_count), 0);
    checkOutput("win_fifo_level", 32'(bus.fifo_level), 0);
    checkOutput("win_sb_empty",   32'(exp_q.size()),   0);

    $display("[TB] read collision");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 12'(16 * i), 12'd0, 16'h1000 + 16'(i), 1'b1, 14'h0062);
      expectWrite(tb_addr(16 * i, 0), 16'h1000 + 16'(i));
      @(negedge clk);
      checkOutput($sformatf("coll_rd_block%0d", i), 32'(bus.sp_wen), 0);
      if (i == 1) begin
        checkOutput("coll_rd_valid", 32'(bus.rd_valid), 1);
        checkOutput("coll_rd_data",  32'(bus.rd_data),  32'h0000A5A5);
      end
    end
    applyStimulus(1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 14'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("coll_drain%0d", k), 32'(bus.sp_wen), 1);
    end

    $display("[TB] overflow and saturation");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i < 6, 12'(16 * i), 12'd5, 16'h2000 + 16'(i), 1'b1, 14'h0);
      if (i < 4) expectWrite(tb_addr(16 * i, 5), 16'h2000 + 16'(i));
    end
    @(negedge clk);
    checkOutput("ovf_fifo_level", 32'(bus.fifo_level), 4);
    checkOutput("ovf_drop_count", 32'(bus.drop_count), 2);
    repeat (6) applyStimulus(1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 14'h0);
    @(negedge clk);
    checkOutput("ovf_sb_empty", 32'(exp_q.size()), 0);
    for (int i = 0; i < 304; i++) begin
      applyStimulus(1'b1, 12'(16 * (i % 32)), 12'd20, 16'h3000 + 16'(i), 1'b1, 14'h0);
      if (i < 4) expectWrite(tb_addr(16 * (i % 32), 20), 16'h3000 + 16'(i));
    end
    @(negedge clk);
    checkOutput("sat_drop_count", 32'(bus.drop_count), 255);
    repeat (6) applyStimulus(1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 14'h0);
    @(negedge clk);
    checkOutput("sat_sb_empty",   32'(exp_q.size()),   0);
    checkOutput("sat_fifo_level", 32'(bus.fifo_level), 0);

    $display("[TB] clear sweep");
    clr_writes  = 0;
    clr_bad     = 0;
    clr_expect  = '0;
    clr_pat_exp = 16'hFFFF;
    clr_mode    = 1'b1;
    startClear(16'hFFFF);
    @(negedge clk);
    checkOutput("clr_busy_rise", 32'(bus.clear_busy), 1);
    done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      applyStimulus((cyc % 7) == 3 && cyc < 17000, 12'((cyc * 16) % 512), 12'(cyc % 512),
                    16'(cyc), (cyc % 16) == 0, 14'(cyc));
      bus.clear_req     = (cyc == 500);
      bus.clear_pattern = 16'h0000;
      @(negedge clk);
      if (!bus.clear_busy) done = 1'b1;
    end
    checkOutput("clr_done",   32'(done),       1);
    checkOutput("clr_writes", 32'(clr_writes), 16384);
    checkOutput("clr_bad",    32'(clr_bad),    0);
    applyStimulus(1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 14'h0);
    @(negedge clk);
    clr_mode = 1'b0;
    checkOutput("clr_fifo_level", 32'(bus.fifo_level), 0);
    checkOutput("clr_drop_count", 32'(bus.drop_count), 255);

    $display("[TB] reset during sweep");
    clr_writes  = 0;
    clr_bad     = 0;
    clr_expect  = '0;
    clr_pat_exp = 16'h1234;
    clr_mode    = 1'b1;
    startClear(16'h1234);
    done = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      applyStimulus(cyc == 90 || cyc == 91, 12'(16 * cyc), 12'd9, 16'h4000 + 16'(cyc), 1'b0, 14'h0);
      @(negedge clk);
      if (clr_writes == 100) done = 1'b1;
    end
    checkOutput("mid_reached", 32'(done), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    clr_mode = 1'b0;
    @(negedge clk);
    checkOutput("mid_sp_wen",     32'(bus.sp_wen),     0);
    checkOutput("mid_rd_valid",   32'(bus.rd_valid),   0);
    checkOutput("mid_clear_busy", 32'(bus.clear_busy), 0);
    checkOutput("mid_drop_count", 32'(bus.drop_count), 0);
    checkOutput("mid_fifo_level", 32'(bus.fifo_level), 0);
    checkOutput("mid_sp_addr",    32'(bus.sp_addr),    0);
    checkOutput("mid_clr_bad",    32'(clr_bad),        0);
    applyStimulus(1'b1, 12'd48, 12'd7, 16'hBEEF, 1'b0, 14'h0);
    expectWrite(tb_addr(48, 7), 16'hBEEF);
    repeat (4) applyStimulus(1'b0, 12'h0, 12'h0, 16'h0, 1'b0, 14'h0);
    @(negedge clk);
    checkOutput("post_sb_empty",   32'(exp_q.size()),   0);
    checkOutput("post_fifo_level", 32'(bus.fifo_level), 0);

    checkOutput("unexpected_writes", 32'(unexp_writes), 0);
    checkOutput("write_during_read", 32'(overlap_errs), 0);
    checkOutput("rd_valid_timing",   32'(rdv_errs),     0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
